// File: rtl/vin_temp_monitor_pkg.sv
// vin_temp_monitor_pkg
// Shared types and constants for the temperature monitor slice.
//   alarm_state_e : NORMAL / WARN / TRIP alarm levels
//   fill_state_e  : FILL while the averaging window is incomplete, RUN after
//   TEMP_MIN/MAX  : plausible DS18B20 range (-55..125 degC, 1/16 degC units)
//   POR_VALUE     : the sensor's power-on reading (85 degC), suspect until valid
package vin_temp_monitor_pkg;

  typedef enum logic [1:0] {
    ALARM_NORMAL,
    ALARM_WARN,
    ALARM_TRIP
  } alarm_state_e;

  typedef enum logic {
    FILL,
    RUN
  } fill_state_e;

  localparam logic signed [15:0] TEMP_MIN  = -16'sd880;
  localparam logic signed [15:0] TEMP_MAX  = 16'sd2000;
  localparam logic signed [15:0] POR_VALUE = 16'sh0550;

  function automatic logic temp_in_range(input logic signed [15:0] t);
    return (t >= TEMP_MIN) && (t <= TEMP_MAX);
  endfunction

endpackage

// File: rtl/vin_temp_monitor_avg8.sv
// temp_avg8
// Eight-entry circular sample buffer with a running sum.
//   clk, rst   : clock, asynchronous active-high reset
//   wr_en      : write one accepted sample this cycle
//   wr_data    : the sample to write (signed 1/16 degC)
//   avg        : registered mean of the buffer (sum >>> 3)
//   avg_next   : the mean the buffer will hold after this cycle's write
module temp_avg8
  import vin_temp_monitor_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic signed [15:0] wr_data,
  output logic signed [15:0] avg,
  output logic signed [15:0] avg_next
);

  logic signed [15:0] buf_q [8];
  logic signed [15:0] buf_d [8];
  logic        [2:0]  ptr_q, ptr_d;
  logic signed [18:0] sum_q, sum_d;

  // The slot under the pointer is the oldest entry; its value leaves the sum
  // as the new sample enters. Empty slots hold 0, so filling needs no special case.
  always_comb begin
    buf_d = buf_q;
    ptr_d = ptr_q;
    sum_d = sum_q;
    if (wr_en) begin
      buf_d[ptr_q] = wr_data;
      ptr_d        = ptr_q + 3'd1;
      sum_d        = sum_q + {{3{wr_data[15]}}, wr_data}
                           - {{3{buf_q[ptr_q][15]}}, buf_q[ptr_q]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) buf_q[i] <= '0;
      ptr_q <= '0;
      sum_q <= '0;
    end else begin
      buf_q <= buf_d;
      ptr_q <= ptr_d;
      sum_q <= sum_d;
    end
  end

  assign avg      = 16'(sum_q >>> 3);
  assign avg_next = 16'(sum_d >>> 3);

endmodule

// File: rtl/vin_temp_monitor.sv
// vin_temp_monitor
// Samples a raw DS18B20 temperature periodically, rejects implausible
// readings, and reports an 8-sample average, min/max and alarm levels.
//   clk, rst          : clock, asynchronous active-high reset
//   temperature       : raw reading from a slower clock domain
//   temperature_avg   : mean of last 8 accepted samples (last sample while filling)
//   temperature_min/max: extremes of accepted samples since reset
//   valid             : 8 samples have been accepted
//   warn, trip        : alarm levels (trip implies warn)
//   sample_err        : one-cycle pulse for a rejected sample
module vin_temp_monitor
  import vin_temp_monitor_pkg::*;
#(
  parameter int                 SAMPLE_CYCLES = 2400000,
  parameter logic signed [15:0] WARN_LIMIT    = 16'sd960,
  parameter logic signed [15:0] TRIP_LIMIT    = 16'sd1280,
  parameter logic signed [15:0] HYST          = 16'sd32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] temperature,
  output logic signed [15:0] temperature_avg,
  output logic signed [15:0] temperature_min,
  output logic signed [15:0] temperature_max,
  output logic               valid,
  output logic               warn,
  output logic               trip,
  output logic               sample_err
);

  localparam int CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

  logic signed [15:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CW-1:0]      tick_cnt_q, tick_cnt_d;
  logic [1:0]         tries_q, tries_d;
  logic               acc_q, acc_d, err_q, err_d;
  logic signed [15:0] acc_data_q, acc_data_d;
  logic [3:0]         count_q, count_d;
  fill_state_e        fill_q, fill_d;
  alarm_state_e       alarm_q, alarm_d;
  logic signed [15:0] last_q, last_d, min_q, min_d, max_q, max_d;
  logic signed [15:0] avg8, avg8_next;
  logic               tick, coherent, capture, sample_ok;

  // Capture stage: a tick opens up to four attempt cycles; the sample is only
  // taken when both synchroniser stages agree. A new tick restarts attempts.
  always_comb begin
    sync1_d    = temperature;
    sync2_d    = sync1_q;
    tick       = (tick_cnt_q == CW'(SAMPLE_CYCLES - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    coherent   = (sync1_q == sync2_q);
    capture    = (tick || (tries_q != 2'd0)) && coherent;
    tries_d    = 2'd0;
    if (tick) begin
      tries_d = coherent ? 2'd0 : 2'd3;
    end else if (tries_q != 2'd0 && !coherent) begin
      tries_d = tries_q - 2'd1;
    end
    // The power-on value is only suspicious until the average is trusted.
    sample_ok  = temp_in_range(sync2_q) && !((sync2_q == POR_VALUE) && (fill_q == FILL));
    acc_d      = capture && sample_ok;
    err_d      = capture && !sample_ok;
    acc_data_d = sync2_q;
  end

  temp_avg8 u_avg8 (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (acc_q),
    .wr_data  (acc_data_q),
    .avg      (avg8),
    .avg_next (avg8_next)
  );

  // Update stage: statistics, fill and alarm state all change on the cycle
  // after capture so every output moves together two cycles after capture.
  // The alarm sees the average as it will be published, including on the
  // accept that completes the window.
  always_comb begin
    count_d = count_q;
    fill_d  = fill_q;
    last_d  = last_q;
    min_d   = min_q;
    max_d   = max_q;
    alarm_d = alarm_q;
    if (acc_q) begin
      last_d = acc_data_q;
      if (count_q != 4'd8) count_d = count_q + 4'd1;
      if (count_q == 4'd7) fill_d = RUN;
      if (count_q == 4'd0) begin
        min_d = acc_data_q;
        max_d = acc_data_q;
      end else begin
        if (acc_data_q < min_q) min_d = acc_data_q;
        if (acc_data_q > max_q) max_d = acc_data_q;
      end
      if (fill_d == RUN) begin
        case (alarm_q)
          ALARM_NORMAL: begin
            if (avg8_next >= TRIP_LIMIT)      alarm_d = ALARM_TRIP;
            else if (avg8_next >= WARN_LIMIT) alarm_d = ALARM_WARN;
          end
          ALARM_WARN: begin
            if (avg8_next >= TRIP_LIMIT)                alarm_d = ALARM_TRIP;
            else if (avg8_next < WARN_LIMIT - HYST)     alarm_d = ALARM_NORMAL;
          end
          ALARM_TRIP: begin
            if (avg8_next < TRIP_LIMIT - HYST) alarm_d = ALARM_WARN;
          end
          default: alarm_d = ALARM_NORMAL;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      tick_cnt_q <= '0;
      tries_q    <= '0;
      acc_q      <= 1'b0;
      err_q      <= 1'b0;
      acc_data_q <= '0;
      count_q    <= '0;
      fill_q     <= FILL;
      alarm_q    <= ALARM_NORMAL;
      last_q     <= '0;
      min_q      <= '0;
      max_q      <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      tick_cnt_q <= tick_cnt_d;
      tries_q    <= tries_d;
      acc_q      <= acc_d;
      err_q      <= err_d;
      acc_data_q <= acc_data_d;
      count_q    <= count_d;
      fill_q     <= fill_d;
      alarm_q    <= alarm_d;
      last_q     <= last_d;
      min_q      <= min_d;
      max_q      <= max_d;
    end
  end

  assign valid           = (fill_q == RUN);
  assign temperature_avg = valid ? avg8 : last_q;
  assign temperature_min = min_q;
  assign temperature_max = max_q;
  assign warn            = (alarm_q != ALARM_NORMAL);
  assign trip            = (alarm_q == ALARM_TRIP);
  assign sample_err      = err_q;

endmodule
